// File: rtl/board_draw_pkg.sv
// Shared types and board geometry for the board draw sequencer.
package board_draw_pkg;

  localparam int unsigned BOARD_ROWS = 10;
  localparam int unsigned BOARD_COLS = 40;
  localparam int unsigned FB_COORD_W = 11;
  localparam int unsigned CELL_COL_W = 6;
  localparam int unsigned CELL_ROW_W = 4;
  localparam int unsigned PIX_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAW,
    FINISH
  } state_e;

endpackage

// File: rtl/board_draw_sequencer_raster_counter.sv
// Two-dimensional nested counter: x runs 0..x_lim_i inner, y runs 0..y_lim_i outer.
module raster_counter #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic [XW-1:0] x_lim_i,
  input  logic [YW-1:0] y_lim_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap;

  assign x_wrap = (x_q == x_lim_i);
  assign last_o = x_wrap && (y_q == y_lim_i);
  assign x_o    = x_q;
  assign y_o    = y_q;

  // After the final position both axes return to zero, ready for the next pass.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = (y_q == y_lim_i) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/board_draw_sequencer.sv
// Sequences framebuffer writes for a full-screen clear or a snapshot draw of the game board.
module board_draw_sequencer
  import board_draw_pkg::*;
#(
  parameter int unsigned CELL_PX  = 16,
  parameter int unsigned X0       = 0,
  parameter int unsigned Y0       = 0,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [BOARD_COLS-1:0] data_in_i [BOARD_ROWS-1:0],
  input  logic                  draw_req_i,
  input  logic                  clear_req_i,
  output logic [FB_COORD_W-1:0] pix_x_o,
  output logic [FB_COORD_W-1:0] pix_y_o,
  output logic                  pix_color_o,
  output logic                  pix_write_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q;
  logic                  clear_pend_q, draw_pend_q, last_q;
  logic [BOARD_COLS-1:0] snap_q [BOARD_ROWS-1:0];
  logic [FB_COORD_W-1:0] pix_x_q, pix_y_q;
  logic                  pix_color_q, pix_write_q, busy_q, done_q;

  logic [FB_COORD_W-1:0] clr_x, clr_y;
  logic                  clr_last;
  logic [CELL_COL_W-1:0] cell_c;
  logic [CELL_ROW_W-1:0] cell_r;
  logic                  cell_last;
  logic [PIX_CNT_W-1:0]  px, py;
  logic                  px_last;

  logic                  clear_go, draw_go, clear_step, draw_step, cell_step;
  logic                  cell_bit, draw_last;
  logic [FB_COORD_W-1:0] draw_x, draw_y;

  // A step loads the counters' current position into the output registers and advances them.
  assign clear_go   = (state_q == IDLE) && (clear_pend_q || clear_req_i);
  assign draw_go    = (state_q == IDLE) && !clear_go && (draw_pend_q || draw_req_i);
  assign clear_step = clear_go || ((state_q == CLEAR) && !last_q);
  assign draw_step  = draw_go || ((state_q == DRAW) && !last_q);
  assign cell_step  = draw_step && px_last;
  assign draw_last  = cell_last && px_last;

  assign draw_x = FB_COORD_W'(X0 + 32'(cell_c) * CELL_PX + 32'(px));
  assign draw_y = FB_COORD_W'(Y0 + 32'(cell_r) * CELL_PX + 32'(py));

  // The first cell is emitted on the dispatch edge, before the snapshot register holds the board.
  assign cell_bit = draw_go ? data_in_i[cell_r][cell_c] : snap_q[cell_r][cell_c];

  raster_counter #(.XW(FB_COORD_W), .YW(FB_COORD_W)) u_clear_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (clear_step),
    .x_lim_i (FB_COORD_W'(SCREEN_W - 1)),
    .y_lim_i (FB_COORD_W'(SCREEN_H - 1)),
    .x_o     (clr_x),
    .y_o     (clr_y),
    .last_o  (clr_last)
  );

  raster_counter #(.XW(CELL_COL_W), .YW(CELL_ROW_W)) u_cell_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (cell_step),
    .x_lim_i (CELL_COL_W'(BOARD_COLS - 1)),
    .y_lim_i (CELL_ROW_W'(BOARD_ROWS - 1)),
    .x_o     (cell_c),
    .y_o     (cell_r),
    .last_o  (cell_last)
  );

  raster_counter #(.XW(PIX_CNT_W), .YW(PIX_CNT_W)) u_pix_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (draw_step),
    .x_lim_i (PIX_CNT_W'(CELL_PX - 1)),
    .y_lim_i (PIX_CNT_W'(CELL_PX - 1)),
    .x_o     (px),
    .y_o     (py),
    .last_o  (px_last)
  );

  always_ff @(posedge clk_i) begin
    if (draw_go) begin
      snap_q <= data_in_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      clear_pend_q <= 1'b0;
      draw_pend_q  <= 1'b0;
      last_q       <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= 1'b0;
      pix_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      clear_pend_q <= clear_pend_q | clear_req_i;
      draw_pend_q  <= draw_pend_q | draw_req_i;

      case (state_q)
        IDLE: begin
          if (clear_go) begin
            state_q      <= CLEAR;
            clear_pend_q <= 1'b0;
          end else if (draw_go) begin
            state_q     <= DRAW;
            draw_pend_q <= 1'b0;
          end
        end
        CLEAR, DRAW: begin
          if (last_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // last_q marks that the write now on the outputs is the final one of the operation.
      if (clear_step) begin
        pix_x_q     <= clr_x;
        pix_y_q     <= clr_y;
        pix_color_q <= 1'b0;
        pix_write_q <= 1'b1;
        busy_q      <= 1'b1;
        last_q      <= clr_last;
      end else if (draw_step) begin
        pix_x_q     <= draw_x;
        pix_y_q     <= draw_y;
        pix_color_q <= cell_bit;
        pix_write_q <= 1'b1;
        busy_q      <= 1'b1;
        last_q      <= draw_last;
      end else begin
        pix_write_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_color_o = pix_color_q;
  assign pix_write_o = pix_write_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Scoreboard bench for board_draw_sequencer on a small 8x4 screen with 2-pixel cells.
module tb_board_draw_sequencer;

  localparam int CELL_PX = 2;
  localparam int X0      = 4;
  localparam int Y0      = 2;
  localparam int SW      = 8;
  localparam int SH      = 4;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drawReq = 1'b0;
  logic        clearReq = 1'b0;
  logic [39:0] dataIn [9:0];
  logic [10:0] pixX, pixY;
  logic        pixColor, pixWrite, busy, done;

  wr_t expQ[$];
  wr_t monGot, monExp;
  int  nEval = 0;
  int  nFail = 0;
  int  obsWrites, obsDones, obsBusy;
  int  wrCycle[$];
  int  doneCycle[$];
  wr_t firstWr [5];

  board_draw_sequencer #(
    .CELL_PX(CELL_PX), .X0(X0), .Y0(Y0), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .data_in_i   (dataIn),
    .draw_req_i  (drawReq),
    .clear_req_i (clearReq),
    .pix_x_o     (pixX),
    .pix_y_o     (pixY),
    .pix_color_o (pixColor),
    .pix_write_o (pixWrite),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #10 clk = ~clk;

  // Monitor: every write on the framebuffer port must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pixWrite) begin
      monGot = {pixX, pixY, pixColor};
      nEval++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL unexpectedWrite: got (%0d,%0d,c%0d), expected no write",
                 pixX, pixY, pixColor);
      end else begin
        monExp = expQ.pop_front();
        if (monGot !== monExp) begin
          nFail++;
          $display("[TB] FAIL writeData: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                   monGot.x, monGot.y, monGot.c, monExp.x, monExp.y, monExp.c);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    nEval++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushClear();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        expQ.push_back({11'(x), 11'(y), 1'b0});
  endtask

  task automatic pushDraw(input logic [39:0] b [9:0], input int limit);
    int k;
    k = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 40; c++)
        for (int py = 0; py < CELL_PX; py++)
          for (int px = 0; px < CELL_PX; px++) begin
            if (k < limit)
              expQ.push_back({11'(X0 + c * CELL_PX + px), 11'(Y0 + r * CELL_PX + py), b[r][c]});
            k++;
          end
  endtask

  task automatic applyStimulus(input logic clr, input logic drw);
    tick();
    clearReq = clr;
    drawReq  = drw;
    tick();
    clearReq = 1'b0;
    drawReq  = 1'b0;
  endtask

  // Samples outputs each cycle until expDones done pulses are seen, then for tail more cycles.
  task automatic observe(input int expDones, input int limit, input int tail);
    int cyc;
    int tailLeft;
    cyc = 0;
    tailLeft = tail;
    obsWrites = 0;
    obsDones = 0;
    obsBusy = 0;
    wrCycle.delete();
    doneCycle.delete();
    forever begin
      @(negedge clk);
      if (pixWrite) begin
        if (obsWrites < 5) firstWr[obsWrites] = {pixX, pixY, pixColor};
        obsWrites++;
        wrCycle.push_back(cyc);
      end
      if (done) begin
        obsDones++;
        doneCycle.push_back(cyc);
      end
      if (busy) obsBusy++;
      cyc++;
      if (obsDones >= expDones) begin
        if (tailLeft == 0) break;
        tailLeft--;
      end else if (cyc >= limit) begin
        checkOutput("observeTimeout", obsDones, expDones);
        break;
      end
    end
  endtask

  task automatic setPattern(input logic [39:0] seed);
    for (int r = 0; r < 10; r++)
      dataIn[r] = seed ^ (40'(r) * 40'h01_0101_0101);
  endtask

  int expX [5] = '{4, 5, 4, 5, 6};
  int expY [5] = '{2, 2, 3, 3, 2};
  int expC [5] = '{1, 1, 1, 1, 0};
  int n;
  int cyc;

  initial begin
    for (int r = 0; r < 10; r++) dataIn[r] = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetPixX", int'(pixX), 0);
    checkOutput("resetPixY", int'(pixY), 0);
    checkOutput("resetColor", int'(pixColor), 0);
    checkOutput("resetWrite", int'(pixWrite), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);

    $display("[TB] draw with single lit cell");
    dataIn[0] = 40'h1;
    pushDraw(dataIn, 1600);
    applyStimulus(1'b0, 1'b1);
    observe(1, 2000, 6);
    checkOutput("t1Writes", obsWrites, 1600);
    checkOutput("t1Dones", obsDones, 1);
    checkOutput("t1Busy", obsBusy, 1600);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t1W%0dX", i + 1), int'(firstWr[i].x), expX[i]);
      checkOutput($sformatf("t1W%0dY", i + 1), int'(firstWr[i].y), expY[i]);
      checkOutput($sformatf("t1W%0dC", i + 1), int'(firstWr[i].c), expC[i]);
    end
    if (obsDones > 0 && obsWrites > 0)
      checkOutput("t1DoneGap", doneCycle[0] - wrCycle[wrCycle.size() - 1], 1);

    $display("[TB] clear alone");
    pushClear();
    applyStimulus(1'b1, 1'b0);
    observe(1, 200, 6);
    checkOutput("t2Writes", obsWrites, 32);
    checkOutput("t2Busy", obsBusy, 32);
    checkOutput("t2Dones", obsDones, 1);
    checkOutput("t2W2X", int'(firstWr[1].x), 1);
    checkOutput("t2W5X", int'(firstWr[4].x), 4);
    if (obsDones > 0 && obsWrites >= 32)
      checkOutput("t2DoneGap", doneCycle[0] - wrCycle[31], 1);

    $display("[TB] clear and draw together");
    setPattern(40'hC3_5A96_F00F);
    pushClear();
    pushDraw(dataIn, 1600);
    applyStimulus(1'b1, 1'b1);
    observe(2, 3000, 6);
    checkOutput("t3Writes", obsWrites, 1632);
    checkOutput("t3Dones", obsDones, 2);
    if (obsWrites >= 33)
      checkOutput("t3GapCycles", wrCycle[32] - wrCycle[31], 3);

    $display("[TB] board toggling during draw");
    setPattern(40'h96_0FF0_3CA5);
    pushDraw(dataIn, 1600);
    tick();
    drawReq = 1'b1;
    tick();
    drawReq = 1'b0;
    for (int r = 0; r < 10; r++) dataIn[r] = ~dataIn[r];
    fork
      observe(1, 2000, 6);
      begin
        repeat (1650) begin
          tick();
          for (int r = 0; r < 10; r++) dataIn[r] = ~dataIn[r];
        end
      end
    join
    checkOutput("t4Writes", obsWrites, 1600);
    checkOutput("t4Dones", obsDones, 1);

    $display("[TB] reset in the middle of a draw");
    setPattern(40'h3C_A55A_0FF0);
    pushDraw(dataIn, 100);
    applyStimulus(1'b0, 1'b1);
    n = 0;
    cyc = 0;
    while (n < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pixWrite) n++;
      drawReq = (n == 50);
      if (n == 100) reset = 1'b1;
    end
    checkOutput("t5Reached100", n, 100);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drawReq = 1'b0;
    @(negedge clk);
    checkOutput("t5WriteAfterReset", int'(pixWrite), 0);
    checkOutput("t5BusyAfterReset", int'(busy), 0);
    checkOutput("t5DoneAfterReset", int'(done), 0);
    observe(0, 40, 40);
    checkOutput("t5IdleWrites", obsWrites, 0);
    checkOutput("t5IdleDones", obsDones, 0);
    checkOutput("t5QueueEmpty", expQ.size(), 0);

    $display("[TB] coalesced draw requests");
    setPattern(40'hA5_F00F_5AC3);
    pushDraw(dataIn, 1600);
    pushDraw(dataIn, 1600);
    applyStimulus(1'b0, 1'b1);
    fork
      observe(2, 4000, 6);
      begin
        repeat (3) begin
          repeat (300) tick();
          drawReq = 1'b1;
          tick();
          drawReq = 1'b0;
        end
      end
    join
    checkOutput("t6Writes", obsWrites, 3200);
    checkOutput("t6Dones", obsDones, 2);
    if (obsWrites >= 1601)
      checkOutput("t6GapCycles", wrCycle[1600] - wrCycle[1599], 3);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nEval, nFail);
    $finish;
  end

endmodule

// File: doc/board_draw_sequencer.md
Name: board_draw_sequencer

Overview:
- Sequences pixel writes into the single-port VGA_framebuffer for the game display.
- Two operations: a full-screen clear, and a draw of a snapshot of the 10x40 one-bit game board as filled square cells.
- Arbitrates clear and draw requests from the game FSM and emits one framebuffer write per cycle.
- Sits between the game-play FSM and VGA_framebuffer, as the only driver of its x/y/pixel_color/pixel_write inputs.

Parameters:
- CELL_PX, 16: side length of one board cell in pixels; power of two, 1..16.
- X0, 0: x pixel origin of board column 0.
- Y0, 0: y pixel origin of board row 0.
- SCREEN_W, 640: clear width in pixels.
- SCREEN_H, 480: clear height in pixels.

Ports:
- Clock  in  1  system clock (50 MHz, same as framebuffer clk50).
- Reset  in  1  synchronous, active-high reset.
- dataIn  in  40 x [9:0] (unpacked rows 9..0, 40 bits each)  board; dataIn[r][c]=1 means cell row r, col c lit; col 0 is leftmost.
- draw_req  in  1  single-cycle pulse; request board draw.
- clear_req  in  1  single-cycle pulse; request screen clear.
- pix_x  out  11  framebuffer x.
- pix_y  out  11  framebuffer y.
- pix_color  out  1  framebuffer pixel value.
- pix_write  out  1  framebuffer write strobe.
- busy  out  1  high while CLEAR or DRAW is active.
- done  out  1  one-cycle pulse after the last write of an operation.

Behaviour:
- FSM states: IDLE, CLEAR, DRAW, FINISH.
- All outputs are registered.
- Reset values: state=IDLE, pix_x=0, pix_y=0, pix_color=0, pix_write=0, busy=0, done=0, both pending flags=0, all counters=0.
- Pending flags: clear_pend and draw_pend are set by their req pulse in any non-reset cycle. Repeated requests coalesce into the flag (no queue depth).
- IDLE dispatch priority:
  - If clear_pend or clear_req: go to CLEAR and consume clear.
  - Else if draw_pend or draw_req: go to DRAW, consume draw, and latch a snapshot of dataIn in the same edge.
  - The first pix_write appears in the cycle after that edge (latency 1).
- CLEAR:
  - Raster order: y 0..SCREEN_H-1 outer, x 0..SCREEN_W-1 inner.
  - pix_color=0, pix_write=1 every cycle.
  - Exactly SCREEN_W*SCREEN_H writes.
- DRAW:
  - Order: row r 0..9, col c 0..39, then py 0..CELL_PX-1, px 0..CELL_PX-1 (cell-major, pixel-minor).
  - pix_x = X0 + c*CELL_PX + px; pix_y = Y0 + r*CELL_PX + py.
  - pix_color = snapshot[r][c]; pix_write=1.
  - Exactly 400*CELL_PX^2 writes.
  - Changes on dataIn during DRAW have no effect on the draw in progress.
- FINISH:
  - Lasts one cycle: pix_write=0, done=1, busy=0, then IDLE.
  - A pending request is dispatched from IDLE on the next cycle, so back-to-back operations have a 2-cycle gap with no writes.
- busy=1 from the first write cycle through the last write cycle inclusive.
- Arithmetic: coordinates are computed 11 bits wide; overflow past 2047 wraps silently. Choosing X0/Y0/CELL_PX so the board fits on screen is the user's responsibility.
- Simultaneous clear_req and draw_req in IDLE: clear runs first, draw stays pending and runs after the clear's FINISH.
- Request arriving in the FINISH cycle: it is pended and dispatched normally.
- Reset mid-operation: immediate IDLE, pix_write=0 on the next cycle, pending flags cleared, no done pulse.

Decomposition:
- Package board_draw_pkg holds:
  - state enum (IDLE, CLEAR, DRAW, FINISH);
  - constants BOARD_ROWS=10, BOARD_COLS=40, FB_COORD_W=11.
- One natural sub-module: raster_counter, a 2-D nested counter with programmable limits and wrap/last flags.
  - Used three times: clear x/y, cell r/c, pixel px/py.
  - Alternatively two instances plus inline logic for the third.

Test Plan (CELL_PX=2, SCREEN_W=8, SCREEN_H=4, X0=4, Y0=2 unless noted):
1. Reset, then draw_req with dataIn all zero except dataIn[0][0]=1:
   - 1600 writes;
   - first write is (4,2,color 1); writes 2-4 are (5,2),(4,3),(5,3) with color 1;
   - write 5 is (6,2,color 0);
   - done pulses once, one cycle after the last write.
2. clear_req alone:
   - 32 writes, color 0, (0,0)..(7,3) in raster order;
   - busy high for exactly 32 cycles, done once.
3. clear_req and draw_req on the same cycle:
   - 32 clear writes, 2 idle cycles, then 1600 draw writes;
   - two done pulses.
4. Toggle every dataIn bit on each cycle during DRAW:
   - output colors match the snapshot taken at dispatch.
5. Assert Reset at write 100 of a draw, with draw_req pulsed during busy:
   - pix_write=0 the next cycle; no done pulse;
   - no further writes until a new request.
6. Three draw_req pulses during busy:
   - exactly one additional draw follows (coalescing);
   - total of 2 done pulses.
